// File: rtl/ram_2port_bist_pkg.sv
// Shared definitions for the dual-port RAM built-in self-test: FSM state
// encodings, data-pattern mode codes and the pass-count width.
package ram_2port_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Pattern selector codes; the unused code 2'b11 behaves like PAT_ADDR.
    localparam logic [1:0] PAT_ADDR  = 2'b00;
    localparam logic [1:0] PAT_NADDR = 2'b01;
    localparam logic [1:0] PAT_CHK   = 2'b10;

    localparam int PASS_W = 4;

endpackage

// File: rtl/ram_sdp.sv
// Inferred simple dual-port RAM: one write port, one read port with a
// registered output (1-cycle read latency).
module ram_sdp #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Synchronous write and registered read.
    // NOTE: the array has no reset so it maps onto block RAM; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/ram_2port_bist.sv
// Self-test wrapper for a simple dual-port RAM: writes a selectable pattern
// on port A, reads it back on port B, and logs mismatches across a
// programmable number of passes.
module ram_2port_bist
    import ram_2port_bist_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int ERR_W  = 8
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [PASS_W-1:0] passes,
    input  logic              err_inj,
    output logic              busy,
    output logic              done,
    output logic              pass_ok,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [ADDR_W-1:0] first_err_addr
);

    state_t              state;
    logic [1:0]          mode_q;
    logic [PASS_W-1:0]   pass_tgt;
    logic [PASS_W-1:0]   pass_idx;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   exp_word;
    logic [DATA_W-1:0]   ram_wdata;
    logic [DATA_W-1:0]   ram_rdata;
    logic                ram_we;
    logic                inj_bit;
    logic                cmp_valid;
    logic [ADDR_W-1:0]   cmp_addr;
    logic [DATA_W-1:0]   cmp_exp;
    logic                mismatch;

    // Base pattern for one address, before the per-pass inversion.
    function automatic logic [DATA_W-1:0] pat_word(input logic [1:0] m,
                                                   input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] a_ext;
        logic [DATA_W-1:0] chk;
        a_ext = DATA_W'(a);
        for (int i = 0; i < DATA_W; i++) begin
            chk[i] = (i % 2 == 0) ^ a[0];
        end
        case (m)
            PAT_ADDR:  pat_word = a_ext;
            PAT_NADDR: pat_word = ~a_ext;
            PAT_CHK:   pat_word = chk;
            default:   pat_word = a_ext;
        endcase
    endfunction

    // Pattern generator, write-data error injection and read-back compare.
    // NOTE: every output gets a value on every path, so no latch can be inferred.
    always_comb begin
        exp_word  = pat_word(mode_q, addr) ^ {DATA_W{pass_idx[0]}};
        inj_bit   = err_inj && (pass_idx == '0) && (addr == '0);
        ram_we    = (state == ST_WRITE);
        ram_wdata = exp_word ^ DATA_W'(inj_bit);
        mismatch  = cmp_valid && (ram_rdata != cmp_exp);
    end

    ram_sdp #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (sys_clk),
        .we    (ram_we),
        .waddr (addr),
        .wdata (ram_wdata),
        .raddr (addr),
        .rdata (ram_rdata)
    );

    // Test sequencer: FSM, counters, compare pipeline and error logging.
    // NOTE: all state updates are non-blocking so every flop samples pre-edge values.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state          <= ST_IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass_ok        <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            mode_q         <= PAT_ADDR;
            pass_tgt       <= '0;
            pass_idx       <= '0;
            addr           <= '0;
            cmp_valid      <= 1'b0;
            cmp_addr       <= '0;
            cmp_exp        <= '0;
        end else begin
            done      <= 1'b0;
            cmp_valid <= 1'b0;

            if (mismatch) begin
                if (err_cnt == '0) begin
                    first_err_addr <= cmp_addr;
                end
                if (err_cnt != '1) begin
                    err_cnt <= err_cnt + ERR_W'(1);
                end
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mode_q         <= mode;
                        pass_tgt       <= (passes == '0) ? PASS_W'(1) : passes;
                        pass_idx       <= '0;
                        addr           <= '0;
                        err_cnt        <= '0;
                        first_err_addr <= '0;
                        pass_ok        <= 1'b0;
                        busy           <= 1'b1;
                        state          <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    addr <= addr + ADDR_W'(1);
                    if (addr == '1) begin
                        state <= ST_READ;
                    end
                end
                ST_READ: begin
                    cmp_valid <= 1'b1;
                    cmp_addr  <= addr;
                    cmp_exp   <= exp_word;
                    addr      <= addr + ADDR_W'(1);
                    if (addr == '1) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (pass_idx + PASS_W'(1) == pass_tgt) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass_ok <= (err_cnt == '0) && !mismatch;
                        state   <= ST_DONE;
                    end else begin
                        pass_idx <= pass_idx + PASS_W'(1);
                        state    <= ST_WRITE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_2port_bist.sv
// Self-checking bench for ram_2port_bist: a behavioural run model predicts
// timing, write-bus traffic and final results; a second instance with its
// read data forced to zero exercises error-counter saturation.
module tb_ram_2port_bist;

    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 5;
    localparam int DEPTH    = 32;
    localparam int PASS_CYC = 2 * DEPTH + 1;

    logic              sys_clk = 1'b0;
    logic              sys_rst = 1'b1;
    logic              start   = 1'b0;
    logic [1:0]        mode    = 2'b00;
    logic [3:0]        passes  = 4'd0;
    logic              err_inj = 1'b0;

    logic              busy, done, pass_ok;
    logic [7:0]        err_cnt;
    logic [ADDR_W-1:0] first_err_addr;
    logic              s_busy, s_done, s_pass_ok;
    logic [3:0]        s_err_cnt;
    logic [ADDR_W-1:0] s_first_err_addr;

    int n_checks = 0;
    int n_errors = 0;

    // Shared run description written by the driver, read by the monitor.
    int         edge_count = 0;
    bit         run_active = 1'b0;
    int         run_t      = 0;
    int         run_len    = 0;
    logic [1:0] run_mode   = 2'b00;
    bit         run_inj    = 1'b0;
    int         exp_err = 0, exp_first = 0, sat_err = 0, sat_first = 0;
    bit         exp_ok = 1'b0, sat_ok = 1'b0;
    logic [7:0] cap_w0, cap_w1;
    logic       cap_busy, cap_done0, cap_done;

    always #5 sys_clk = ~sys_clk;

    ram_2port_bist #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ERR_W(8)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .mode(mode),
        .passes(passes), .err_inj(err_inj), .busy(busy), .done(done),
        .pass_ok(pass_ok), .err_cnt(err_cnt), .first_err_addr(first_err_addr)
    );

    ram_2port_bist #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ERR_W(4)) dut_sat (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .mode(mode),
        .passes(passes), .err_inj(err_inj), .busy(s_busy), .done(s_done),
        .pass_ok(s_pass_ok), .err_cnt(s_err_cnt), .first_err_addr(s_first_err_addr)
    );

    // The saturation instance always reads back zero.
    initial force dut_sat.ram_rdata = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] pat(input logic [1:0] m, input int a);
        logic [7:0] av;
        av = 8'(a);
        case (m)
            2'd1:    return ~av;
            2'd2:    return (a % 2 == 0) ? 8'h55 : 8'hAA;
            default: return av;
        endcase
    endfunction

    function automatic logic [7:0] wword(input logic [1:0] m, input int p, input int a, input bit inj);
        logic [7:0] w;
        w = pat(m, a) ^ ((p % 2 == 1) ? 8'hFF : 8'h00);
        if (inj && p == 0 && a == 0) w = w ^ 8'h01;
        return w;
    endfunction

    // Whole-run model: fill memory, read back, count mismatches.
    task automatic model_run(input logic [1:0] m, input int p, input bit inj, input bit forced,
                             input int emax, output int ecnt, output int faddr, output bit ok);
        logic [7:0] mem [DEPTH];
        logic [7:0] got, want;
        int np;
        bit seen;
        np = (p == 0) ? 1 : p;
        ecnt = 0; faddr = 0; seen = 1'b0;
        for (int k = 0; k < np; k++) begin
            for (int a = 0; a < DEPTH; a++) mem[a] = wword(m, k, a, inj);
            for (int a = 0; a < DEPTH; a++) begin
                want = pat(m, a) ^ ((k % 2 == 1) ? 8'hFF : 8'h00);
                got  = forced ? 8'h00 : mem[a];
                if (got != want) begin
                    if (!seen) faddr = a;
                    seen = 1'b1;
                    if (ecnt < emax) ecnt++;
                end
            end
        end
        ok = !seen;
    endtask

    // Per-cycle monitor: timeline, write bus and held results for both instances.
    always begin
        int  o, wp, wa;
        bit  eb, ed;
        @(posedge sys_clk);
        edge_count++;
        #1;
        eb = 1'b0; ed = 1'b0; o = 0;
        if (run_active) begin
            o  = edge_count - run_t;
            eb = (o >= 0) && (o < run_len);
            ed = (o == run_len);
        end
        check("busy", 32'(busy), 32'(eb));
        check("done", 32'(done), 32'(ed));
        check("sat_busy", 32'(s_busy), 32'(eb));
        check("sat_done", 32'(s_done), 32'(ed));
        if (eb) begin
            check("pass_ok_busy", 32'(pass_ok), 32'(0));
            check("sat_pass_ok_busy", 32'(s_pass_ok), 32'(0));
            wp = o / PASS_CYC;
            wa = o % PASS_CYC;
            if (wa < DEPTH) begin
                check("we", 32'(dut.ram_we), 32'(1));
                check("waddr", 32'(dut.addr), 32'(wa));
                check("wdata", 32'(dut.ram_wdata), 32'(wword(run_mode, wp, wa, run_inj)));
            end else begin
                check("we_idle", 32'(dut.ram_we), 32'(0));
            end
        end else begin
            check("err_cnt", 32'(err_cnt), 32'(exp_err));
            check("first_err_addr", 32'(first_err_addr), 32'(exp_first));
            check("pass_ok", 32'(pass_ok), 32'(exp_ok));
            check("sat_err_cnt", 32'(s_err_cnt), 32'(sat_err));
            check("sat_first_err_addr", 32'(s_first_err_addr), 32'(sat_first));
            check("sat_pass_ok", 32'(s_pass_ok), 32'(sat_ok));
        end
    end

    task automatic clear_expect();
        run_active = 1'b0;
        exp_err = 0; exp_first = 0; exp_ok = 1'b0;
        sat_err = 0; sat_first = 0; sat_ok = 1'b0;
    endtask

    // One run: start pulse, optional ignored start at extra_at, optional reset at abort_at.
    task automatic run_test(input logic [1:0] m, input int p, input bit inj,
                            input int extra_at, input int abort_at);
        int np;
        np = (p == 0) ? 1 : p;
        @(negedge sys_clk);
        mode = m; passes = 4'(p); err_inj = inj; start = 1'b1;
        run_t = edge_count + 1; run_len = np * PASS_CYC;
        run_mode = m; run_inj = inj;
        model_run(m, p, inj, 1'b0, 255, exp_err, exp_first, exp_ok);
        model_run(m, p, inj, 1'b1, 15, sat_err, sat_first, sat_ok);
        run_active = 1'b1;
        for (int i = 0; i <= run_len + 2; i++) begin
            @(negedge sys_clk);
            start = (i == extra_at);
            if (i == extra_at) begin
                mode = ~m; passes = 4'd7;
            end
            if (i == 0) cap_w0 = dut.ram_wdata;
            if (i == PASS_CYC) cap_w1 = dut.ram_wdata;
            if (i == run_len - 1) begin
                cap_busy = busy; cap_done0 = done;
            end
            if (i == run_len) cap_done = done;
            if (i == abort_at) begin
                sys_rst = 1'b1;
                clear_expect();
            end
            if (abort_at >= 0 && i == abort_at + 1) begin
                check("abort_busy", 32'(busy), 32'(0));
                check("abort_done", 32'(done), 32'(0));
                check("abort_err_cnt", 32'(err_cnt), 32'(0));
                sys_rst = 1'b0;
                break;
            end
        end
        err_inj = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_pass_ok", 32'(pass_ok), 32'(0));
        check("rst_err_cnt", 32'(err_cnt), 32'(0));
        check("rst_first_err_addr", 32'(first_err_addr), 32'(0));

        // Address pattern, single pass: done at start+66.
        run_test(2'b00, 1, 1'b0, -1, -1);
        check("t1_busy_last", 32'(cap_busy), 32'(1));
        check("t1_done_early", 32'(cap_done0), 32'(0));
        check("t1_done", 32'(cap_done), 32'(1));
        check("t1_pass_ok", 32'(pass_ok), 32'(1));
        check("t1_err_cnt", 32'(err_cnt), 32'(0));

        // Checkerboard, three passes: inversion on odd pass, done at start+196.
        run_test(2'b10, 3, 1'b0, -1, -1);
        check("t2_w_pass0_addr0", 32'(cap_w0), 32'h55);
        check("t2_w_pass1_addr0", 32'(cap_w1), 32'hAA);
        check("t2_done", 32'(cap_done), 32'(1));
        check("t2_pass_ok", 32'(pass_ok), 32'(1));

        // Injected error in inverted-address mode: exactly one mismatch at 0.
        run_test(2'b01, 2, 1'b1, -1, -1);
        check("t3_w_addr0", 32'(cap_w0), 32'hFE);
        check("t3_err_cnt", 32'(err_cnt), 32'(1));
        check("t3_first_err_addr", 32'(first_err_addr), 32'(0));
        check("t3_pass_ok", 32'(pass_ok), 32'(0));

        // Saturation on the forced-zero instance.
        run_test(2'b10, 2, 1'b0, -1, -1);
        check("t4_sat_err_cnt", 32'(s_err_cnt), 32'd15);
        repeat (5) @(negedge sys_clk);
        check("t4_sat_err_hold", 32'(s_err_cnt), 32'd15);

        // Reset 20 cycles into a run, then a clean run.
        run_test(2'b00, 2, 1'b0, -1, 20);
        repeat (2) @(negedge sys_clk);
        run_test(2'b00, 1, 1'b0, -1, -1);
        check("t5_pass_ok", 32'(pass_ok), 32'(1));

        // Extra start while busy is ignored; passes=0 means one pass.
        run_test(2'b11, 0, 1'b0, 10, -1);
        check("t6_done", 32'(cap_done), 32'(1));
        check("t6_pass_ok", 32'(pass_ok), 32'(1));

        // Randomized runs checked by the monitor against the model.
        for (int r = 0; r < 8; r++) begin
            run_test(2'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                     1'($urandom_range(0, 1)), -1, -1);
        end

        repeat (3) @(negedge sys_clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
